register_arbiter: RTL and testbench
===================================

# register_arbiter

Round-robin arbiter that shares one `DATA_WIDTH`-bit holding register between `NUM_REQ` requesters. Each requester offers a write with a valid/ready handshake. The block grants one write at a time, updates the register, and reports which requester last wrote it. After each write it enforces a programmable guard interval before the next grant. It sits between several producers and the shared register stage of the datapath, and owns the sequencing of that register.

## Interface
- `DATA_WIDTH`, 16, register and request data width
- `NUM_REQ`, 4, number of requesters (2..16)
- `GUARD_CYCLES`, 2, idle cycles forced after every accepted write (0..255)
- `RESET_VALUE`, 0, register contents after reset
- `CLK` in 1: the single clock; all logic on rising edge
- `RST` in 1: synchronous, active-high reset
- `REQ_VALID` in `NUM_REQ`: per-requester write request
- `REQ_DATA` in `NUM_REQ*DATA_WIDTH`: packed request data, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `REQ_READY` out `NUM_REQ`: grant, one-hot or zero
- `DATA_OUT` out `DATA_WIDTH`: current register contents
- `OWNER` out `$clog2(NUM_REQ)`: index of the last requester to write
- `UPDATE` out 1: one-cycle pulse, high the cycle `DATA_OUT` shows new data
- `BUSY` out 1: high while in the GUARD state

## Operation
- FSM has two states, IDLE and GUARD.
- **IDLE:**
  - The winner is the first requester with `REQ_VALID` set, searching from `ptr` upward and wrapping modulo `NUM_REQ`.
  - `REQ_READY` is combinational: one-hot on the winner, all zeros if no valid is set.
- **Accept** occurs when `REQ_VALID[i] && REQ_READY[i]`. On the next edge:
  - `DATA_OUT` takes `REQ_DATA[i]`.
  - `OWNER` takes i.
  - `UPDATE` goes to 1.
  - `ptr` takes (i+1) mod `NUM_REQ`.
  - The counter loads `GUARD_CYCLES`, and the FSM goes to GUARD if `GUARD_CYCLES` > 0, else stays in IDLE.
- **GUARD:**
  - `REQ_READY` is all zeros and `BUSY` is 1.
  - The counter decrements each cycle. The FSM returns to IDLE on the edge where the counter reaches 1, so exactly `GUARD_CYCLES` cycles are spent in GUARD.
- The register holds its value whenever no accept occurs. `UPDATE` is 0 in every cycle not following an accept.
- Requesters must hold `REQ_VALID` and `REQ_DATA` stable until accepted. Dropping valid before acceptance withdraws the request and is legal.
- Width rules:
  - Counter width is 8 bits.
  - `ptr` width is `$clog2(NUM_REQ)`. Wrap is explicit (compare to `NUM_REQ`-1), because `NUM_REQ` need not be a power of two.

## Timing
- Reset values, taking effect on the first edge with `RST`=1:
  - `DATA_OUT`=`RESET_VALUE`, `OWNER`=0, `UPDATE`=0, `BUSY`=0, `REQ_READY`=0.
  - Internal: `ptr`=0, counter=0, state IDLE.
- Reset during GUARD aborts the guard. Reset on an accept edge discards the write, and the register shows `RESET_VALUE`.
- Latency is 1 cycle: an accept at edge n makes `DATA_OUT` valid after edge n+1, with `UPDATE` high for that one cycle.
- With `GUARD_CYCLES`=G, the minimum accept-to-accept spacing is G+1 cycles. G=0 allows one write per cycle.
- Simultaneous requests: exactly one is granted per accept. The others stay pending and keep their position relative to the rotated `ptr`.
- A requester that has just won gets lowest priority on the next arbitration. This guarantees no starvation: a held request is granted within `NUM_REQ` accepts.

## Structure
- Package `register_arbiter_pkg`:
  - state enum `{IDLE, GUARD}`
  - localparam `GUARD_W`=8
  - function computing the index width as max(1, `$clog2(NUM_REQ)`)
- Sub-module `rr_picker`:
  - inputs: `REQ_VALID` vector and `ptr`
  - outputs: one-hot grant and encoded index
  - purely combinational, parameterised by `NUM_REQ`
- The top level holds the FSM, counter, pointer and register.

## Test plan
- **Reset:** with `RESET_VALUE`=16'hA5A5, assert `RST` 3 cycles. Expect `DATA_OUT`=A5A5, `OWNER`=0, `UPDATE`=0, `REQ_READY`=0 after the first reset edge.
- **Single request:** `REQ_VALID`=4'b0100 with data 16'h1234, G=2. Expect:
  - `REQ_READY`=0100 in the same cycle.
  - Next cycle `DATA_OUT`=1234, `OWNER`=2, `UPDATE`=1, `BUSY`=1.
  - `BUSY` high for exactly 2 cycles.
- **Round robin:** all four valid continuously, G=0, data = 16'h1000+i. Expect grants 0,1,2,3,0 on consecutive cycles, and `OWNER` sequence 0,1,2,3,0 lagging by one cycle.
- **Guard spacing:** G=3, requesters 1 and 3 both valid. Expect:
  - Accepts 4 cycles apart, order 1 then 3.
  - `REQ_READY`=0 throughout GUARD even though valids remain high.
- **Withdraw and wrap:** `ptr`=3 (after a write by 2), then only requester 0 valid. Expect grant 0, and next `ptr`=1.
  - Drop requester 1 valid during GUARD: no grant is issued to it afterwards.
- **Reset mid-guard:** during cycle 1 of a G=5 guard, assert `RST` 1 cycle. Expect `BUSY`=0, `DATA_OUT`=`RESET_VALUE`, and a grant available in the first cycle after reset deasserts.

Source files
------------

// File: rtl/register_arbiter_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
package register_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GUARD = 1'b1
  } state_t;

  localparam int unsigned GUARD_W = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/register_arbiter_if.sv
// Requester-side handshake and register-view bundle of the arbiter.
interface register_arbiter_if
  import register_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 4
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            REQ_READY;
  logic [DATA_WIDTH-1:0]         DATA_OUT;
  logic [IDX_W-1:0]              OWNER;
  logic                          UPDATE;
  logic                          BUSY;

  modport master (
    output REQ_VALID, REQ_DATA,
    input  REQ_READY, DATA_OUT, OWNER, UPDATE, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_DATA,
    output REQ_READY, DATA_OUT, OWNER, UPDATE, BUSY
  );

endinterface

// File: rtl/register_arbiter_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_picker
  import register_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              i_valid,
  input  logic [idx_width(NUM_REQ)-1:0]   i_ptr,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic [idx_width(NUM_REQ)-1:0]   o_idx,
  output logic                            o_any
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic [31:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    // Explicit wrap: NUM_REQ need not be a power of two.
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_cand = 32'(i_ptr) + off;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      if (!o_any && i_valid[w_cand[IDX_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_cand[IDX_W-1:0];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = o_any && (o_idx == i[IDX_W-1:0]);
    end
  end

endmodule

// File: rtl/register_arbiter.sv
// Round-robin arbiter owning one shared holding register, with a post-write guard interval.
module register_arbiter
  import register_arbiter_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 16,
  parameter int unsigned           NUM_REQ      = 4,
  parameter int unsigned           GUARD_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                CLK,
  input  logic                RST,
  register_arbiter_if.slave   bus
);

  localparam int unsigned        IDX_W   = idx_width(NUM_REQ);
  localparam logic [GUARD_W-1:0] G_LOAD  = GUARD_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]   PTR_MAX = IDX_W'(NUM_REQ - 1);

  state_t                r_state, w_state_nxt;
  logic [GUARD_W-1:0]    r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [IDX_W-1:0]      r_owner, w_owner_nxt;
  logic                  r_update, w_update_nxt;
  logic [NUM_REQ-1:0]    w_ready;

  logic [NUM_REQ-1:0]    w_pick_grant;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_any;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_valid (bus.REQ_VALID),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ptr_nxt    = r_ptr;
    w_data_nxt   = r_data;
    w_owner_nxt  = r_owner;
    w_update_nxt = 1'b0;
    w_ready      = '0;
    case (r_state)
      IDLE: begin
        w_ready = w_pick_grant;
        if (w_pick_any) begin
          w_data_nxt   = bus.REQ_DATA[32'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          w_owner_nxt  = w_pick_idx;
          w_update_nxt = 1'b1;
          w_ptr_nxt    = (w_pick_idx == PTR_MAX) ? '0 : w_pick_idx + 1'b1;
          w_cnt_nxt    = G_LOAD;
          if (G_LOAD != '0) begin
            w_state_nxt = GUARD;
          end
        end
      end
      GUARD: begin
        // Leaving on the count-of-1 edge gives exactly GUARD_CYCLES busy cycles.
        if (r_cnt <= GUARD_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_data   <= RESET_VALUE;
      r_owner  <= '0;
      r_update <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ptr    <= w_ptr_nxt;
      r_data   <= w_data_nxt;
      r_owner  <= w_owner_nxt;
      r_update <= w_update_nxt;
    end
  end

  assign bus.REQ_READY = w_ready;
  assign bus.DATA_OUT  = r_data;
  assign bus.OWNER     = r_owner;
  assign bus.UPDATE    = r_update;
  assign bus.BUSY      = (r_state == GUARD);

endmodule

// File: tb/tb_register_arbiter.sv
// Four arbiters (guard 2, 0, 3, 5) share one stimulus; a queue-free arbitration model checks all every cycle.
`timescale 1ns/1ps
module tb_register_arbiter;

  localparam int unsigned   DW    = 16;
  localparam int unsigned   NR    = 4;
  localparam int unsigned   NI    = 4;
  localparam int unsigned   IW    = 2;
  localparam logic [31:0]   GPACK = {8'd5, 8'd3, 8'd0, 8'd2};
  localparam logic [DW-1:0] RV    = 16'hA5A5;

  typedef enum int {F_READY, F_DOUT, F_OWNER, F_UPDATE, F_BUSY} fld_t;
  typedef struct {
    int          k;
    fld_t        f;
    logic [31:0] v;
    string       nm;
  } pin_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    valid = '0;
  logic [NR*DW-1:0] data = '0;

  logic [NR-1:0] a_ready [NI];
  logic [DW-1:0] a_dout  [NI];
  logic [IW-1:0] a_owner [NI];
  logic          a_update[NI];
  logic          a_busy  [NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    register_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
    register_arbiter #(
      .DATA_WIDTH   (DW),
      .NUM_REQ      (NR),
      .GUARD_CYCLES (int'(GPACK[k*8 +: 8])),
      .RESET_VALUE  (RV)
    ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
    );
    assign bus.REQ_VALID = valid;
    assign bus.REQ_DATA  = data;
    assign a_ready[k]    = bus.REQ_READY;
    assign a_dout[k]     = bus.DATA_OUT;
    assign a_owner[k]    = bus.OWNER;
    assign a_update[k]   = bus.UPDATE;
    assign a_busy[k]     = bus.BUSY;
  end

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_data  [NI];
  int            m_owner [NI];
  bit            m_update[NI];
  int            m_ptr   [NI];
  int            m_left  [NI];
  bit            m_ok = 1'b0;

  function automatic int winner(input int ptr, input logic [NR-1:0] v);
    for (int j = 0; j < int'(NR); j++) begin
      int c;
      c = (ptr + j) % int'(NR);
      if (v[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < int'(NI); k++) begin
      if (rst) begin
        m_data[k] = RV; m_owner[k] = 0; m_update[k] = 1'b0; m_ptr[k] = 0; m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k]   = m_left[k] - 1;
        m_update[k] = 1'b0;
      end else begin
        int w;
        w = winner(m_ptr[k], valid);
        if (w >= 0) begin
          m_data[k]   = data[w*DW +: DW];
          m_owner[k]  = w;
          m_update[k] = 1'b1;
          m_ptr[k]    = (w + 1) % int'(NR);
          m_left[k]   = int'(GPACK[k*8 +: 8]);
        end else begin
          m_update[k] = 1'b0;
        end
      end
    end
    if (rst) m_ok = 1'b1;
  end

  // ---------------- compare process ----------------
  int   total = 0;
  int   bad   = 0;
  pin_t pins[$];

  function automatic void chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endfunction

  function automatic logic [31:0] act_of(input int k, input fld_t f);
    case (f)
      F_READY:  return 32'(a_ready[k]);
      F_DOUT:   return 32'(a_dout[k]);
      F_OWNER:  return 32'(a_owner[k]);
      F_UPDATE: return 32'(a_update[k]);
      default:  return 32'(a_busy[k]);
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      for (int k = 0; k < int'(NI); k++) begin
        logic [NR-1:0] er;
        int w;
        er = '0;
        if (m_left[k] == 0) begin
          w = winner(m_ptr[k], valid);
          if (w >= 0) er = NR'(1) << w;
        end
        chk("ready",  k, 32'(a_ready[k]),  32'(er));
        chk("data",   k, 32'(a_dout[k]),   32'(m_data[k]));
        chk("owner",  k, 32'(a_owner[k]),  32'(m_owner[k]));
        chk("update", k, 32'(a_update[k]), 32'(m_update[k]));
        chk("busy",   k, 32'(a_busy[k]),   32'(m_left[k] > 0));
      end
    end
    foreach (pins[i]) chk(pins[i].nm, pins[i].k, act_of(pins[i].k, pins[i].f), pins[i].v);
    pins.delete();
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input int k, input fld_t f, input logic [31:0] v, input string nm);
    pins.push_back('{k, f, v, nm});
  endtask

  task automatic pulse_reset();
    rst = 1'b1; valid = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three edges.
    step();
    for (int k = 0; k < int'(NI); k++) begin
      pin(k, F_DOUT, 32'hA5A5, "rst_data");
      pin(k, F_OWNER, 0, "rst_owner");
      pin(k, F_UPDATE, 0, "rst_update");
      pin(k, F_READY, 0, "rst_ready");
      pin(k, F_BUSY, 0, "rst_busy");
    end
    step(); step();
    rst = 1'b0;

    // Single request from requester 2 (dut0: G=2, dut1: G=0).
    valid = 4'b0100; data[2*DW +: DW] = 16'h1234;
    pin(0, F_READY, 4'b0100, "single_ready");
    step();
    valid = '0;
    pin(0, F_DOUT, 16'h1234, "single_data");
    pin(0, F_OWNER, 2, "single_owner");
    pin(0, F_UPDATE, 1, "single_update");
    pin(0, F_BUSY, 1, "single_busy1");
    pin(1, F_BUSY, 0, "single_g0_busy");
    step();
    pin(0, F_BUSY, 1, "single_busy2");
    pin(0, F_UPDATE, 0, "single_update_off");
    step();
    pin(0, F_BUSY, 0, "single_busy_end");

    // Round robin, all valid, dut1 (G=0).
    pulse_reset();
    valid = 4'b1111; data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    pin(1, F_READY, 4'b0001, "rr_grant0");
    step();
    pin(1, F_READY, 4'b0010, "rr_grant1"); pin(1, F_OWNER, 0, "rr_owner0"); pin(1, F_DOUT, 16'h1000, "rr_data0");
    step();
    pin(1, F_READY, 4'b0100, "rr_grant2"); pin(1, F_OWNER, 1, "rr_owner1");
    step();
    pin(1, F_READY, 4'b1000, "rr_grant3"); pin(1, F_OWNER, 2, "rr_owner2");
    step();
    pin(1, F_READY, 4'b0001, "rr_grant4"); pin(1, F_OWNER, 3, "rr_owner3"); pin(1, F_DOUT, 16'h1003, "rr_data3");
    step();
    pin(1, F_OWNER, 0, "rr_owner4"); pin(1, F_UPDATE, 1, "rr_update4");
    valid = '0;

    // Guard spacing, requesters 1 and 3, dut2 (G=3).
    pulse_reset();
    valid = 4'b1010; data = {16'h2333, 16'h0, 16'h2111, 16'h0};
    pin(2, F_READY, 4'b0010, "gs_first");
    step();
    pin(2, F_OWNER, 1, "gs_owner1"); pin(2, F_DOUT, 16'h2111, "gs_data1"); pin(2, F_READY, 0, "gs_ready_g1");
    step();
    pin(2, F_READY, 0, "gs_ready_g2");
    step();
    pin(2, F_READY, 0, "gs_ready_g3"); pin(2, F_BUSY, 1, "gs_busy_g3");
    step();
    pin(2, F_BUSY, 0, "gs_idle"); pin(2, F_READY, 4'b1000, "gs_second");
    step();
    pin(2, F_OWNER, 3, "gs_owner3"); pin(2, F_DOUT, 16'h2333, "gs_data3"); pin(2, F_UPDATE, 1, "gs_update3");
    valid = '0;

    // Withdraw and wrap, dut0 (G=2).
    pulse_reset();
    valid = 4'b0100; data = {16'h0, 16'h3222, 16'h0, 16'h0};
    pin(0, F_READY, 4'b0100, "ww_first");
    step();
    valid = 4'b0011; data[0 +: DW] = 16'h3000; data[DW +: DW] = 16'h3111;
    pin(0, F_OWNER, 2, "ww_owner2"); pin(0, F_READY, 0, "ww_guard_ready");
    step(); step();
    pin(0, F_READY, 4'b0001, "ww_wrap_grant");
    step();
    valid = 4'b0101; data[2*DW +: DW] = 16'h3444;
    pin(0, F_OWNER, 0, "ww_owner0"); pin(0, F_DOUT, 16'h3000, "ww_data0");
    step(); step();
    pin(0, F_READY, 4'b0100, "ww_skip_withdrawn");
    step();
    pin(0, F_OWNER, 2, "ww_owner_after"); pin(0, F_DOUT, 16'h3444, "ww_data_after");
    valid = '0;

    // Reset during a G=5 guard (dut3); dut1 sees a reset on its accept edge.
    pulse_reset();
    valid = 4'b0001; data = {16'h0, 16'h0, 16'h0, 16'h4000};
    step();
    rst = 1'b1; valid = 4'b0010; data[DW +: DW] = 16'h4111;
    pin(3, F_BUSY, 1, "rg_busy_before"); pin(3, F_DOUT, 16'h4000, "rg_data_before");
    step();
    rst = 1'b0;
    pin(3, F_BUSY, 0, "rg_busy_after"); pin(3, F_DOUT, 16'hA5A5, "rg_data_reset");
    pin(3, F_READY, 4'b0010, "rg_grant_avail"); pin(1, F_DOUT, 16'hA5A5, "rg_discarded_write");
    step();
    valid = '0;
    pin(3, F_DOUT, 16'h4111, "rg_data_new"); pin(3, F_OWNER, 1, "rg_owner_new");
    step(); step();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
